// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared types and constants for the seven-segment scan driver.
//   bcd_t      : one BCD digit (4 bits)
//   SEG_*      : active-low segment patterns, bit order {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
package seg_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

endpackage

// File: rtl/seg_scan_driver_bcd_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7
// Purely combinational BCD to active-low seven-segment decoder.
// Ports:
//   i_bcd : BCD digit in (0..9 valid; 10..15 shown as a dash)
//   o_seg : segment pattern {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module bcd_to_seg7
  import seg_pkg::*;
(
  input  bcd_t       i_bcd,
  output logic [6:0] o_seg
);

  // NOTE: every path of a combinational block must assign its outputs
  // (here via the default arm) or synthesis infers a latch.
  always_comb begin
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexes three BCD digits onto an active-low three-digit
// seven-segment display. Digits are snapshotted once per scan frame so a
// digit never changes mid-frame; hold freezes the snapshot (lap display).
// Optional build macro: SEG_LZB_EN enables leading-zero blanking of
// digits 2 and 1 (the anode keeps scanning; only the segments blank).
// Parameters:
//   SCAN_DIV : clock cycles each digit stays lit (>= 2)
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   en   : display enable; 0 blanks outputs, scanning keeps running
//   hold : 1 freezes the snapshot
//   d2/d1/d0 : BCD digits, d2 most significant
//   seg  : segment drive {g,f,e,d,c,b,a}, active-low
//   an   : anode drive, active-low; an[i] selects digit i
// -----------------------------------------------------------------------------
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       hold,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  output logic [6:0] seg,
  output logic [2:0] an
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  bcd_t          r_snap2, r_snap1, r_snap0;
  logic [6:0]    r_seg;
  logic [2:0]    r_an;

  logic          w_tick;
  bcd_t          w_digit;
  logic          w_blank;
  logic [6:0]    w_dec;
  logic [6:0]    w_seg_next;

  assign w_tick = (r_presc == PW'(SCAN_DIV - 1));

  // Digit currently being scanned; idx never reaches 3, so the default
  // arm only serves digit 2.
  always_comb begin
    w_digit = r_snap2;
    w_blank = 1'b0;
    case (r_idx)
      2'd0:    w_digit = r_snap0;
      2'd1:    w_digit = r_snap1;
      default: w_digit = r_snap2;
    endcase
`ifdef SEG_LZB_EN
    w_blank = ((r_idx == 2'd2) && (r_snap2 == 4'd0)) ||
              ((r_idx == 2'd1) && (r_snap2 == 4'd0) && (r_snap1 == 4'd0));
`else
    w_blank = 1'b0;
`endif
  end

  bcd_to_seg7 u_dec (
    .i_bcd (w_digit),
    .o_seg (w_dec)
  );

  assign w_seg_next = w_blank ? SEG_BLANK : w_dec;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
      r_snap2 <= 4'd0;
      r_snap1 <= 4'd0;
      r_snap0 <= 4'd0;
      r_seg   <= SEG_BLANK;
      r_an    <= 3'b111;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;

      if (w_tick) begin
        r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
        // Frame boundary: load a fresh snapshot unless the lap hold is on.
        if ((r_idx == 2'd2) && !hold) begin
          r_snap2 <= d2;
          r_snap1 <= d1;
          r_snap0 <= d0;
        end
      end

      // Outputs follow idx by one cycle; en only gates this register.
      r_an  <= en ? ~(3'b001 << r_idx) : 3'b111;
      r_seg <= en ? w_seg_next : SEG_BLANK;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
// Self-checking bench for seg_scan_driver (SCAN_DIV = 4). The reference
// model tracks only a cycle count since reset plus the displayed snapshot;
// scan position and frame boundaries are derived arithmetically from it.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       hold;
  logic [3:0] d2, d1, d0;
  logic [6:0] seg;
  logic [2:0] an;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int         cyc = 0;
  logic [3:0] m_snap [3];
  logic [6:0] seg_tab [16];

  seg_scan_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .hold (hold),
    .d2   (d2),
    .d1   (d1),
    .d0   (d0),
    .seg  (seg),
    .an   (an)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] model_seg(input int ix);
    logic blank;
    blank = 1'b0;
`ifdef SEG_LZB_EN
    if (ix == 2 && m_snap[2] == 4'd0) blank = 1'b1;
    if (ix == 1 && m_snap[2] == 4'd0 && m_snap[1] == 4'd0) blank = 1'b1;
`endif
    return blank ? 7'h7F : seg_tab[m_snap[ix]];
  endfunction

  task automatic check(input string tag, input logic [6:0] got_seg, input logic [2:0] got_an,
                       input logic [6:0] exp_seg, input logic [2:0] exp_an);
    checks++;
    assert (got_an === exp_an) else begin
      errors++;
      $error("FAIL %s an cyc=%0d got=%b exp=%b", tag, cyc, got_an, exp_an);
    end
    checks++;
    assert (got_seg === exp_seg) else begin
      errors++;
      $error("FAIL %s seg cyc=%0d got=%h exp=%h", tag, cyc, got_seg, exp_seg);
    end
  endtask

  // One clock: predict from current inputs/model, clock, compare, advance model.
  task automatic step(input string tag);
    logic [2:0] ea;
    logic [6:0] es;
    int p, ix;
    p  = cyc % SCAN_DIV;
    ix = (cyc / SCAN_DIV) % 3;
    if (rst) begin
      ea = 3'b111;
      es = 7'h7F;
    end else if (en) begin
      ea = 3'b111;
      ea[ix] = 1'b0;
      es = model_seg(ix);
    end else begin
      ea = 3'b111;
      es = 7'h7F;
    end
    @(posedge clk);
    #1;
    check(tag, seg, an, es, ea);
    if (rst) begin
      cyc = 0;
      m_snap[0] = 4'd0;
      m_snap[1] = 4'd0;
      m_snap[2] = 4'd0;
    end else begin
      if (p == SCAN_DIV - 1 && ix == 2 && !hold) begin
        m_snap[2] = d2;
        m_snap[1] = d1;
        m_snap[0] = d0;
      end
      cyc++;
    end
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic set_d(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    d2 = a;
    d1 = b;
    d0 = c;
  endtask

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    m_snap[0] = 4'd0;
    m_snap[1] = 4'd0;
    m_snap[2] = 4'd0;

    // Reset scan: two reset cycles, then two full frames.
    rst = 1'b1; en = 1'b1; hold = 1'b0;
    set_d(4'd1, 4'd2, 4'd3);
    run("reset", 2);
    rst = 1'b0;
    run("frame", 24);

    // Frame stability: d0 changes mid-frame, shows only on the next frame.
    run("stab_pre", 6);
    d0 = 4'd7;
    run("stab", 18);

    // Hold: digits change over three frames but the display stays frozen.
    hold = 1'b1;
    set_d(4'd4, 4'd5, 4'd6);
    run("hold456", 12);
    set_d(4'd7, 4'd8, 4'd9);
    run("hold789", 24);
    hold = 1'b0;
    run("unhold", 24);

    // Enable: blank for a few cycles while scanning continues.
    en = 1'b0;
    run("en_off", 5);
    en = 1'b1;
    run("en_on", 7);

    // Non-BCD digit shows a dash.
    set_d(4'd1, 4'hC, 4'd3);
    run("dash", 24);

    // Leading-zero patterns (blanked only when SEG_LZB_EN is defined).
    set_d(4'd0, 4'd0, 4'd5);
    run("lz005", 24);
    set_d(4'd0, 4'd0, 4'd0);
    run("lz000", 24);
    set_d(4'd0, 4'd3, 4'd0);
    run("lz030", 24);

    // Reset mid-operation at idx = 2, presc = 1.
    while ((cyc % (3 * SCAN_DIV)) != 2 * SCAN_DIV + 1) step("align");
    set_d(4'd9, 4'd8, 4'd7);
    rst = 1'b1;
    run("midrst", 1);
    rst = 1'b0;
    run("post_rst", 24);

    // Randomized traffic, including occasional resets and enable/hold toggles.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) set_d(4'($urandom_range(0, 15)),
                                           4'($urandom_range(0, 15)),
                                           4'($urandom_range(0, 15)));
      hold = ($urandom_range(0, 7) == 0);
      en   = ($urandom_range(0, 7) != 0);
      rst  = ($urandom_range(0, 60) == 0);
      step("rand");
    end
    rst = 1'b0; en = 1'b1; hold = 1'b0;
    run("tail", 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
